jam_param: RTL and testbench
============================

Name: jam_param

Overview:
- Parametrised exhaustive job-assignment engine.
- For a runtime-selected worker count n (2..N_MAX), enumerates all n! worker-to-job permutations in lexicographic order and queries an external cost table through the W/J address ports.
- Reports the minimum total cost, the number of permutations achieving it, and the first (lexicographically smallest) optimal assignment.
- Start/busy handshake allows repeated runs without reset.

Parameters:
- N_MAX, 8, maximum workers/jobs (2..8).
- CW, 7, cost word width.
- MC_W, 16, MatchCount width; saturating.
- Derived localparams: IDX_W = clog2(N_MAX); ACC_W = CW + IDX_W.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  run request; sampled only in IDLE
- n_act  in  IDX_W+1  worker count; latched on accepted start
- W  out  IDX_W  worker index of current cost query (registered)
- J  out  IDX_W  job index of current cost query (registered)
- Cost  in  CW  cost of (W,J); combinational from table; valid in same cycle W/J held
- busy  out  1  high from cycle after accepted start through last EVAL
- Valid  out  1  one-cycle pulse: results final
- MinCost  out  ACC_W  minimum total cost
- MatchCount  out  MC_W  count of permutations with cost == MinCost
- BestPerm  out  N_MAX*IDX_W  slice i = job assigned to worker i

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST).
- Reset values:
  - Outputs: W=0, J=0, busy=0, Valid=0, MinCost=all-ones, MatchCount=0, BestPerm=identity (slice i = i).
  - Internal: state=IDLE, perm=identity.
- n_act clamp at latch: <2 → 2; >N_MAX → N_MAX.
- FSM states: IDLE, FETCH, EVAL, DONE.
- IDLE:
  - On start=1: latch n, perm=identity, acc=0, first=1, MinCost=all-ones, MatchCount=0.
  - Also load W=0, J=perm[0]=0; next state FETCH.
- FETCH (counter k=0..n-1, k equals W):
  - Every cycle: acc += Cost.
  - k<n-1: W<=k+1, J<=perm[k+1].
  - k==n-1: go to EVAL.
- EVAL (one cycle):
  - If first or acc<MinCost: MinCost=acc, MatchCount=1, BestPerm=perm; clear first.
  - Else if acc==MinCost: MatchCount+1, saturating at all-ones. BestPerm is unchanged, so it keeps the first lexicographic optimum.
  - If perm is fully descending over 0..n-1 (last permutation): go to DONE.
  - Otherwise: perm=next_perm(perm), acc=0, W=0, J=next_perm[0], go to FETCH.
- DONE: Valid=1 for exactly one cycle, busy=0; next state IDLE.
- Results hold until the next accepted start clears them.
- Cycle count: P = n!; Valid asserts exactly 1 + P*(n+1) cycles after the edge that samples start.
- Next permutation (lexicographic, restricted to indices 0..n-1):
  - pivot = largest i<n-1 with perm[i]<perm[i+1];
  - s = largest j>i with perm[j]>perm[i];
  - swap perm[i] and perm[s]; reverse perm[i+1..n-1].
  - Fully combinational, one cycle.
- Indices ≥n stay identity in perm and in BestPerm.
- Width rules: acc and MinCost are ACC_W; n*(2^CW−1) < 2^ACC_W, so acc never overflows. Cost is zero-extended.
- start while busy or in DONE: ignored.
- RST at any cycle, including mid-FETCH: all reset values on the next edge; a later start works normally.
- W/J change only on clock edges; Cost is sampled at the edge ending each FETCH cycle.

Decomposition:
- Package jam_pkg: FSM state enum; clog2 function; ACC_W/IDX_W derivation helper.
- Sub-module jam_next_perm (combinational):
  - Inputs: perm vector and n.
  - Outputs: next perm vector and is_last flag.
  - Instantiated once.

Test Plan:
1. n=2, N_MAX=8, Cost table C(0,0)=5, C(0,1)=1, C(1,0)=2, C(1,1)=7, start pulse → MinCost=3, MatchCount=1, BestPerm slices {1,0,2,3,4,5,6,7}, Valid exactly 7 cycles after start edge, busy low in that cycle.
2. n=3, Cost=w*j → MinCost=1, MatchCount=1, BestPerm[0..2]={2,1,0}, Valid at 1+6*4=25 cycles.
3. n=3, Cost=(w==0)?j:0 → MinCost=0, MatchCount=2, BestPerm[0..2]={0,1,2} (first lexicographic tie kept).
4. n=8, Cost=1 constant → MinCost=8, MatchCount=40320, Valid at 1+40320*9 cycles; second start immediately after reruns and gives identical results.
5. Clamp: n_act=1 → behaves as n=2 (two permutations, 7 cycles); n_act=12 → behaves as n=8. Also n=8, Cost=127 → MinCost=1016, no overflow.
6. start asserted during busy → ignored, result unchanged; RST asserted mid-FETCH → next cycle all outputs at reset values, busy=0; a new start completes correctly.

Source files
------------

// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared FSM type and width helpers for the job-assignment engine
package jam_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Headroom of clog2(n_max) bits keeps an n-term sum of CW-bit costs from wrapping.
    function automatic int acc_width(input int cost_w, input int n_max);
        return cost_w + clog2(n_max);
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// rtl/jam_next_perm.sv - combinational lexicographic successor over the first n slots
module jam_next_perm
    import jam_pkg::*;
#(
    parameter  int N_MAX = 8,
    localparam int IDX_W = clog2(N_MAX)
) (
    input  logic [N_MAX*IDX_W-1:0] perm,
    input  logic [IDX_W:0]         n,
    output logic [N_MAX*IDX_W-1:0] next_perm,
    output logic                   is_last
);

    logic [IDX_W-1:0] p [N_MAX];
    logic [IDX_W-1:0] q [N_MAX];
    logic [IDX_W-1:0] pivot;
    logic [IDX_W-1:0] succ;
    logic             found;

    always_comb begin
        for (int i = 0; i < N_MAX; i++) begin
            p[i] = perm[i*IDX_W +: IDX_W];
        end

        found = 1'b0;
        pivot = '0;
        for (int i = 0; i < N_MAX - 1; i++) begin
            if (((IDX_W+1)'(i + 1) < n) && (p[i] < p[i+1])) begin
                found = 1'b1;
                pivot = IDX_W'(i);
            end
        end

        // The tail after the pivot is descending, so the last larger element is the smallest one.
        succ = pivot;
        for (int j = 0; j < N_MAX; j++) begin
            if ((IDX_W'(j) > pivot) && ((IDX_W+1)'(j) < n) && (p[j] > p[pivot])) begin
                succ = IDX_W'(j);
            end
        end

        for (int j = 0; j < N_MAX; j++) begin
            q[j] = p[j];
        end
        q[pivot] = p[succ];
        q[succ]  = p[pivot];

        next_perm = '0;
        for (int j = 0; j < N_MAX; j++) begin
            if ((IDX_W'(j) > pivot) && ((IDX_W+1)'(j) < n)) begin
                next_perm[j*IDX_W +: IDX_W] = q[IDX_W'(int'(pivot) + int'(n) - j)];
            end else begin
                next_perm[j*IDX_W +: IDX_W] = q[j];
            end
        end

        is_last = ~found;
    end

endmodule

// File: rtl/jam_param.sv
// rtl/jam_param.sv - exhaustive n-worker job assignment search over an external cost table
module jam_param
    import jam_pkg::*;
#(
    parameter  int N_MAX = 8,
    parameter  int CW    = 7,
    parameter  int MC_W  = 16,
    localparam int IDX_W = clog2(N_MAX),
    localparam int ACC_W = acc_width(CW, N_MAX)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [IDX_W:0]         n_act,
    output logic [IDX_W-1:0]       W,
    output logic [IDX_W-1:0]       J,
    input  logic [CW-1:0]          Cost,
    output logic                   busy,
    output logic                   Valid,
    output logic [ACC_W-1:0]       MinCost,
    output logic [MC_W-1:0]        MatchCount,
    output logic [N_MAX*IDX_W-1:0] BestPerm
);

    localparam logic [IDX_W:0] N_MIN_L = (IDX_W+1)'(2);
    localparam logic [IDX_W:0] N_MAX_L = (IDX_W+1)'(N_MAX);

    function automatic logic [N_MAX*IDX_W-1:0] identity_perm();
        logic [N_MAX*IDX_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_MAX; i++) begin
            v[i*IDX_W +: IDX_W] = IDX_W'(i);
        end
        return v;
    endfunction

    localparam logic [N_MAX*IDX_W-1:0] IDENT = identity_perm();

    function automatic logic [IDX_W-1:0] slice_at(input logic [N_MAX*IDX_W-1:0] v,
                                                  input logic [IDX_W-1:0]       idx);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_MAX; i++) begin
            if (IDX_W'(i) == idx) r = v[i*IDX_W +: IDX_W];
        end
        return r;
    endfunction

    state_t                 state;
    state_t                 state_nx;
    logic [IDX_W:0]         n_r;
    logic [IDX_W:0]         n_clamped;
    logic [N_MAX*IDX_W-1:0] perm;
    logic [N_MAX*IDX_W-1:0] perm_nx;
    logic                   perm_last;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_sum;
    logic                   first;
    logic                   fetch_last;

    always_comb begin
        n_clamped = n_act;
        if (n_act < N_MIN_L) begin
            n_clamped = N_MIN_L;
        end else if (n_act > N_MAX_L) begin
            n_clamped = N_MAX_L;
        end
    end

    assign acc_sum    = acc + ACC_W'(Cost);
    assign fetch_last = ({1'b0, W} == (n_r - (IDX_W+1)'(1)));

    jam_next_perm #(
        .N_MAX(N_MAX)
    ) u_next_perm (
        .perm     (perm),
        .n        (n_r),
        .next_perm(perm_nx),
        .is_last  (perm_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: if (fetch_last) state_nx = S_EVAL;
            S_EVAL:  state_nx = perm_last ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // W doubles as the fetch position counter; J always tracks perm[W].
    always_ff @(posedge CLK) begin
        if (RST) begin
            W          <= '0;
            J          <= '0;
            busy       <= 1'b0;
            Valid      <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
            BestPerm   <= IDENT;
            perm       <= IDENT;
            n_r        <= N_MIN_L;
            acc        <= '0;
            first      <= 1'b1;
        end else begin
            Valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_r        <= n_clamped;
                        perm       <= IDENT;
                        acc        <= '0;
                        first      <= 1'b1;
                        MinCost    <= '1;
                        MatchCount <= '0;
                        W          <= '0;
                        J          <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    acc <= acc_sum;
                    if (!fetch_last) begin
                        W <= W + IDX_W'(1);
                        J <= slice_at(perm, W + IDX_W'(1));
                    end
                end
                S_EVAL: begin
                    if (first || (acc < MinCost)) begin
                        MinCost    <= acc;
                        MatchCount <= MC_W'(1);
                        BestPerm   <= perm;
                        first      <= 1'b0;
                    end else if ((acc == MinCost) && (MatchCount != '1)) begin
                        MatchCount <= MatchCount + MC_W'(1);
                    end
                    if (perm_last) begin
                        busy <= 1'b0;
                    end else begin
                        perm <= perm_nx;
                        acc  <= '0;
                        W    <= '0;
                        J    <= slice_at(perm_nx, IDX_W'(0));
                    end
                end
                S_DONE: begin
                    Valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jam_param.sv
// tb/tb_jam_param.sv - randomized bench for jam_param against a permutation-enumerating model
module tb_jam_param;

    localparam int N_MAX   = 8;
    localparam int CW      = 7;
    localparam int MC_W    = 16;
    localparam int IDX_W   = 3;
    localparam int ACC_W   = 10;
    localparam int MAXP    = 720;
    localparam int S_IDX_W = 2;
    localparam int S_ACC_W = 9;
    localparam int S_MC_W  = 4;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   start;
    logic [IDX_W:0]         n_act;
    logic [IDX_W-1:0]       W;
    logic [IDX_W-1:0]       J;
    logic [CW-1:0]          Cost;
    logic                   busy;
    logic                   Valid;
    logic [ACC_W-1:0]       MinCost;
    logic [MC_W-1:0]        MatchCount;
    logic [N_MAX*IDX_W-1:0] BestPerm;
    logic [CW-1:0]          tab [N_MAX][N_MAX];

    logic                   s_start;
    logic [S_IDX_W:0]       s_n_act;
    logic [S_IDX_W-1:0]     s_W;
    logic [S_IDX_W-1:0]     s_J;
    logic [CW-1:0]          s_Cost;
    logic                   s_busy;
    logic                   s_Valid;
    logic [S_ACC_W-1:0]     s_MinCost;
    logic [S_MC_W-1:0]      s_MatchCount;
    logic [4*S_IDX_W-1:0]   s_BestPerm;

    assign Cost = tab[W][J];

    jam_param #(.N_MAX(N_MAX), .CW(CW), .MC_W(MC_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .n_act(n_act), .W(W), .J(J), .Cost(Cost),
        .busy(busy), .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount), .BestPerm(BestPerm)
    );

    jam_param #(.N_MAX(4), .CW(CW), .MC_W(S_MC_W)) dut_s (
        .CLK(CLK), .RST(RST), .start(s_start), .n_act(s_n_act), .W(s_W), .J(s_J), .Cost(s_Cost),
        .busy(s_busy), .Valid(s_Valid), .MinCost(s_MinCost), .MatchCount(s_MatchCount),
        .BestPerm(s_BestPerm)
    );

    always #5 CLK = ~CLK;

    int     perms [MAXP][N_MAX];
    int     m_best [N_MAX];
    int     m_n, m_p, m_min, m_cnt;
    bit     run_act, wj_zero, chk_en;
    int     run_c0, edge_no;
    longint hold_min, hold_cnt, hold_best;
    int     nvec, nfail;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, edge_no);
        end
    endtask

    function automatic longint pack(input int v [N_MAX]);
        longint r;
        r = 0;
        for (int i = 0; i < N_MAX; i++) r = r | (longint'(v[i]) << (i * IDX_W));
        return r;
    endfunction

    // Permutation r is decoded from its factorial-base digits, which yields lexicographic order.
    task automatic build_model(input int n);
        int avail [N_MAX];
        int rem, f, idx, sum, m;
        m_n = n;
        m_p = 1;
        for (int i = 2; i <= n; i++) m_p *= i;
        m_min = 0;
        m_cnt = 0;
        for (int r = 0; r < m_p; r++) begin
            for (int i = 0; i < N_MAX; i++) avail[i] = i;
            rem = r;
            m = n;
            sum = 0;
            for (int i = 0; i < n; i++) begin
                f = 1;
                for (int k = 2; k <= n - 1 - i; k++) f *= k;
                idx = rem / f;
                rem = rem % f;
                perms[r][i] = avail[idx];
                for (int k = idx; k < m - 1; k++) avail[k] = avail[k+1];
                m--;
                sum += int'(tab[i][perms[r][i]]);
            end
            for (int i = n; i < N_MAX; i++) perms[r][i] = i;
            if (r == 0 || sum < m_min) begin
                m_min = sum;
                m_cnt = 1;
                for (int i = 0; i < N_MAX; i++) m_best[i] = perms[r][i];
            end else if (sum == m_min && m_cnt < (1 << MC_W) - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic set_reset_hold();
        hold_min  = (1 << ACC_W) - 1;
        hold_cnt  = 0;
        hold_best = 24'o76543210;
        wj_zero   = 1'b1;
    endtask

    always @(negedge CLK) begin
        int t, pos, pi;
        edge_no++;
        if (chk_en) begin
            if (run_act) begin
                t = edge_no - run_c0;
                if (t < m_p * (m_n + 1)) begin
                    chk("busy_run", longint'(busy), 1);
                    chk("valid_run", longint'(Valid), 0);
                    pos = t % (m_n + 1);
                    pi  = t / (m_n + 1);
                    if (pos < m_n) begin
                        chk("W_addr", longint'(W), longint'(pos));
                        chk("J_addr", longint'(J), longint'(perms[pi][pos]));
                    end
                end else if (t == m_p * (m_n + 1)) begin
                    chk("busy_done", longint'(busy), 0);
                    chk("valid_done", longint'(Valid), 0);
                end else begin
                    chk("valid_pulse", longint'(Valid), 1);
                    chk("busy_at_valid", longint'(busy), 0);
                    chk("min_cost", longint'(MinCost), longint'(m_min));
                    chk("match_count", longint'(MatchCount), longint'(m_cnt));
                    chk("best_perm", longint'(BestPerm), pack(m_best));
                    hold_min  = longint'(m_min);
                    hold_cnt  = longint'(m_cnt);
                    hold_best = pack(m_best);
                    run_act   = 1'b0;
                end
            end else begin
                chk("busy_idle", longint'(busy), 0);
                chk("valid_idle", longint'(Valid), 0);
                chk("min_hold", longint'(MinCost), hold_min);
                chk("count_hold", longint'(MatchCount), hold_cnt);
                chk("best_hold", longint'(BestPerm), hold_best);
                if (wj_zero) begin
                    chk("W_reset", longint'(W), 0);
                    chk("J_reset", longint'(J), 0);
                end
            end
        end
    end

    task automatic do_run(input int na, input int n_eff);
        @(negedge CLK);
        #1;
        build_model(n_eff);
        run_c0  = edge_no + 1;
        run_act = 1'b1;
        wj_zero = 1'b0;
        n_act   = (IDX_W+1)'(na);
        start   = 1'b1;
        @(negedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k, budget;
        k = 0;
        budget = m_p * (m_n + 1) + 20;
        while (run_act && k < budget) begin
            @(negedge CLK);
            k++;
        end
        #1;
        if (run_act) begin
            nvec++;
            nfail++;
            $display("FAIL run_timeout: got no result expected one within %0d cycles", budget);
            run_act = 1'b0;
        end
    endtask

    task automatic fill_tab(input int mode, input int hi);
        for (int w = 0; w < N_MAX; w++) begin
            for (int j = 0; j < N_MAX; j++) begin
                case (mode)
                    0:       tab[w][j] = CW'($urandom_range(0, hi));
                    1:       tab[w][j] = CW'(w * j);
                    2:       tab[w][j] = (w == 0) ? CW'(j) : CW'(0);
                    default: tab[w][j] = CW'(hi);
                endcase
            end
        end
    endtask

    initial begin
        int k;
        RST = 1'b1; start = 1'b0; n_act = '0;
        s_start = 1'b0; s_n_act = '0; s_Cost = 7'd127;
        nvec = 0; nfail = 0; edge_no = 0;
        chk_en = 1'b0; run_act = 1'b0;
        set_reset_hold();
        fill_tab(3, 0);
        repeat (2) @(negedge CLK);
        #1;
        chk_en = 1'b1;
        @(negedge CLK);
        #1;
        RST = 1'b0;

        fill_tab(3, 0);
        tab[0][0] = 7'd5; tab[0][1] = 7'd1; tab[1][0] = 7'd2; tab[1][1] = 7'd7;
        do_run(2, 2); wait_done();
        chk("t1_min", longint'(MinCost), 3);
        chk("t1_cnt", longint'(MatchCount), 1);
        chk("t1_best", longint'(BestPerm), 24'o76543201);

        fill_tab(1, 0);
        do_run(3, 3); wait_done();
        chk("t2_min", longint'(MinCost), 1);
        chk("t2_cnt", longint'(MatchCount), 1);
        chk("t2_best", longint'(BestPerm), 24'o76543012);

        fill_tab(2, 0);
        do_run(3, 3); wait_done();
        chk("t3_min", longint'(MinCost), 0);
        chk("t3_cnt", longint'(MatchCount), 2);
        chk("t3_best", longint'(BestPerm), 24'o76543210);

        fill_tab(3, 1);
        for (int r = 0; r < 2; r++) begin
            do_run(6, 6); wait_done();
            chk("t4_min", longint'(MinCost), 6);
            chk("t4_cnt", longint'(MatchCount), 720);
        end

        fill_tab(3, 127);
        do_run(6, 6); wait_done();
        chk("t5_max_cost", longint'(MinCost), 762);

        fill_tab(0, 127);
        do_run(1, 2); wait_done();
        fill_tab(0, 127);
        do_run(0, 2); wait_done();

        for (int n = 3; n <= 5; n++) begin
            fill_tab(0, 127); do_run(n, n); wait_done();
            fill_tab(0, 3);   do_run(n, n); wait_done();
        end
        fill_tab(0, 3);
        do_run(6, 6); wait_done();

        fill_tab(0, 15);
        do_run(4, 4);
        repeat (10) @(negedge CLK);
        #1;
        start = 1'b1; n_act = 4'd2;
        @(negedge CLK);
        #1;
        start = 1'b0;
        wait_done();

        fill_tab(0, 15);
        do_run(4, 4);
        repeat (6) @(negedge CLK);
        #1;
        RST = 1'b1;
        run_act = 1'b0;
        set_reset_hold();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        fill_tab(0, 7);
        do_run(3, 3); wait_done();

        @(negedge CLK);
        #1;
        s_n_act = 3'd7;
        s_start = 1'b1;
        @(negedge CLK);
        #1;
        s_start = 1'b0;
        k = 0;
        while (!s_Valid && k < 400) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("s_latency", longint'(k), 121);
        chk("s_valid", longint'(s_Valid), 1);
        chk("s_busy", longint'(s_busy), 0);
        chk("s_min_nowrap", longint'(s_MinCost), 508);
        chk("s_cnt_sat", longint'(s_MatchCount), 15);
        chk("s_best", longint'(s_BestPerm), 8'hE4);

        repeat (2) @(negedge CLK);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
